// File: rtl/seq_detector_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding and the
// helper that sizes the length/fill fields from the maximum pattern width.
package seq_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2,
    HIT  = 2'd3
  } state_t;

  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Masked compare of the candidate history window against the loaded pattern;
// only bits below the programmed length take part.
module seq_window_cmp
  import seq_detector_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic [PAT_W-1:0] window,
  input  logic [PAT_W-1:0] pat,
  input  logic [PAT_W-1:0] mask,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] len_mask;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
  end

  assign hit = ((window ^ pat) & mask & len_mask) == '0;

endmodule

// File: rtl/seq_detector_p.sv
// Runtime-programmable serial pattern detector with registered Moore match pulse.
// Define SEQDET_COUNT_EN to add the saturating match counter (cnt_clr/match_cnt).
module seq_detector_p
  import seq_detector_pkg::*;
#(
  parameter int  PAT_W = 8,
  parameter int  CNT_W = 16,
  localparam int LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  output logic             match,
  output logic             armed
`ifdef SEQDET_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_p: PAT_W must be 2..32 and CNT_W at least 1");
  end

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] window;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W:0]   fill_inc;
  logic             full;
  logic             cmp_hit;
  logic             bit_hit;
  logic             unused_hist_msb;

  assign len_clamp       = (len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;
  assign window          = {hist[PAT_W-2:0], din};
  assign unused_hist_msb = hist[PAT_W-1];
  assign fill_inc        = {1'b0, fill} + (LEN_W+1)'(1);
  assign full            = fill_inc >= {1'b0, len};
  assign bit_hit         = full & cmp_hit;

  seq_window_cmp #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_cmp (
    .window(window),
    .pat   (pattern),
    .mask  (mask),
    .len   (len),
    .hit   (cmp_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pat_load) begin
      state_next = (len_in == '0) ? IDLE : FILL;
    end else if (state != IDLE) begin
      if (din_valid) begin
        if (bit_hit)   state_next = HIT;
        else if (full) state_next = HUNT;
        else           state_next = FILL;
      end else if (state == HIT) begin
        state_next = overlap ? HUNT : FILL;
      end
    end
  end

  always_comb begin
    match = (state == HIT);
    armed = (state != IDLE);
  end

  // A load discards the concurrent din bit; a non-overlapping hit restarts the fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= '0;
      mask    <= '0;
      len     <= '0;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pattern <= pat_in;
      mask    <= mask_in;
      len     <= len_clamp;
      hist    <= '0;
      fill    <= '0;
    end else if (state != IDLE && din_valid) begin
      hist <= window;
      if (bit_hit && !overlap) fill <= '0;
      else if (full)           fill <= len;
      else                     fill <= fill_inc[LEN_W-1:0];
    end
  end

`ifdef SEQDET_COUNT_EN
  logic cnt_inc;

  assign cnt_inc = (state_next == HIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            match_cnt <= '0;
    else if (cnt_clr)                    match_cnt <= CNT_W'(cnt_inc);
    else if (cnt_inc && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_seq_detector_p.sv
// Scoreboard bench for seq_detector_p: the driver queues the expected match/armed
// pair for each clock, a monitor pops and compares after every rising edge.
module tb_seq_detector_p;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       din;
  logic       pat_load;
  logic [7:0] pat_in;
  logic [7:0] mask_in;
  logic [3:0] len_in;
  logic       overlap;
  logic       match;
  logic       armed;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  logic [1:0] exp_q[$];
  int         id_q[$];

  always #5 clk = ~clk;

`ifdef SEQDET_COUNT_EN
  logic       cnt_clr;
  logic [3:0] match_cnt;

  seq_detector_p #(.PAT_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .len_in(len_in), .overlap(overlap),
    .match(match), .armed(armed), .cnt_clr(cnt_clr), .match_cnt(match_cnt)
  );

  task automatic chk_cnt(input logic [3:0] e, input string nm);
    checks++;
    if (match_cnt !== e) begin
      errors++;
      $display("FAIL %s: match_cnt=%0d expected %0d", nm, match_cnt, e);
    end
  endtask
`else
  seq_detector_p #(.PAT_W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .len_in(len_in), .overlap(overlap),
    .match(match), .armed(armed)
  );
`endif

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      int         id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      checks++;
      if ({match, armed} !== e) begin
        errors++;
        $display("FAIL step %0d match/armed: got %b expected %b", id, {match, armed}, e);
      end
    end
  end

  task automatic step(input logic v, input logic d, input logic em, input logic ea);
    din_valid = v;
    din       = d;
    pat_load  = 1'b0;
    exp_q.push_back({em, ea});
    id_q.push_back(step_no);
    step_no++;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] m, input logic [3:0] l,
                      input logic ov, input logic d);
    pat_in    = p;
    mask_in   = m;
    len_in    = l;
    overlap   = ov;
    pat_load  = 1'b1;
    din_valid = 1'b1;
    din       = d;
    exp_q.push_back({1'b0, l != 4'd0});
    id_q.push_back(step_no);
    step_no++;
    @(posedge clk);
    #2;
    pat_load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din_valid = 1'b0; din = 1'b0; pat_load = 1'b0;
    pat_in = '0; mask_in = '0; len_in = '0; overlap = 1'b0;
`ifdef SEQDET_COUNT_EN
    cnt_clr = 1'b0;
`endif
    @(negedge clk);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    rst = 1'b1;
    step(1, 1, 0, 0);
`ifdef SEQDET_COUNT_EN
    chk_cnt(4'd0, "cnt_reset");
`endif

    // 1011 overlapping, upper mask bits set but beyond len
    load(8'h0B, 8'hFF, 4'd4, 1'b1, 1'b0);
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1); step(0, 0, 0, 1);
`ifdef SEQDET_COUNT_EN
    chk_cnt(4'd2, "cnt_1011");
`endif

    // 111 overlapping: back-to-back hits, and a hit again after an idle cycle
    load(8'h07, 8'hFF, 4'd3, 1'b1, 1'b0);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1); step(1, 1, 1, 1);
    step(1, 1, 1, 1); step(0, 0, 0, 1); step(1, 1, 1, 1); step(0, 1, 0, 1);

    // 111 non-overlapping
    load(8'h07, 8'hFF, 4'd3, 1'b0, 1'b0);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    step(0, 0, 0, 1); step(1, 1, 0, 1);

    // don't-care mask 1001
    load(8'h09, 8'h09, 4'd4, 1'b0, 1'b0);
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 1, 1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);

    // gapped valid: invalid cycles carry garbage din that must not shift in
    load(8'h0B, 8'hFF, 4'd4, 1'b1, 1'b0);
    step(1, 1, 0, 1); step(0, 0, 0, 1); step(1, 0, 0, 1); step(0, 1, 0, 1);
    step(1, 1, 0, 1); step(0, 0, 0, 1); step(1, 1, 1, 1); step(0, 0, 0, 1);

    // load with a valid 1 bit: that bit must not count toward the window
    load(8'h0B, 8'hFF, 4'd4, 1'b1, 1'b1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);

    // len_in above PAT_W clamps to 8
    load(8'hA5, 8'hFF, 4'd15, 1'b1, 1'b0);
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 1, 1);

    // reset mid-pattern, then a zero-length load stays disarmed
    load(8'h0B, 8'hFF, 4'd4, 1'b1, 1'b0);
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    rst = 1'b0;
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    load(8'h0B, 8'hFF, 4'd0, 1'b1, 1'b0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);

`ifdef SEQDET_COUNT_EN
    cnt_clr = 1'b1;
    step(0, 0, 0, 0);
    cnt_clr = 1'b0;
    chk_cnt(4'd0, "cnt_clear");
    load(8'h03, 8'hFF, 4'd2, 1'b1, 1'b0);
    step(1, 1, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 1, 1, 1);
    chk_cnt(4'd15, "cnt_saturate");
    cnt_clr = 1'b1;
    step(1, 1, 1, 1);
    cnt_clr = 1'b0;
    chk_cnt(4'd1, "cnt_clr_with_inc");
    step(0, 0, 0, 1);
`endif

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
